// File: rtl/calc_operand_entry.sv
// Operand-entry sequencer: debounces enter/clear buttons and steps a four-state
// entry FSM that latches a BCD operand, an operator and a second BCD operand.
module calc_operand_entry #(
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] sw,
   input  logic       btn_enter,
   input  logic       btn_clear,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic [1:0] op,
   output logic [1:0] stage,
   output logic       operands_valid,
   output logic       digit_err
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ENTER_A  = 2'b00,
      ENTER_OP = 2'b01,
      ENTER_B  = 2'b10,
      DONE     = 2'b11
   } stage_t;

   // Bit 0 is the enter button, bit 1 the clear button.
   logic [1:0]       btn_raw;
   logic [1:0]       sync_p0;
   logic [1:0]       sync_p1;
   logic [1:0]       level;
   logic [1:0]       level_d;
   logic [1:0]       press;
   logic [CNT_W-1:0] cnt [2];
   logic             enter_press;
   logic             clear_press;
   stage_t           state;

   assign btn_raw = {btn_clear, btn_enter};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         level   <= '0;
         level_d <= '0;
         cnt[0]  <= '0;
         cnt[1]  <= '0;
      end else begin
         sync_p0 <= btn_raw;
         sync_p1 <= sync_p0;
         level_d <= level;
         for (int i = 0; i < 2; i++) begin
            if (sync_p1[i] == level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               cnt[i]   <= '0;
               level[i] <= ~level[i];
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Rising edge of the debounced level only; release is silent.
   assign press       = level & ~level_d;
   assign clear_press = press[1];
   assign enter_press = press[0] & ~press[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ENTER_A;
         a              <= '0;
         b              <= '0;
         op             <= '0;
         operands_valid <= 1'b0;
         digit_err      <= 1'b0;
      end else if (clear_press) begin
         state          <= ENTER_A;
         a              <= '0;
         b              <= '0;
         op             <= '0;
         operands_valid <= 1'b0;
         digit_err      <= 1'b0;
      end else if (enter_press) begin
         case (state)
            ENTER_A: begin
               if (sw <= 4'd9) begin
                  a         <= sw;
                  digit_err <= 1'b0;
                  state     <= ENTER_OP;
               end else begin
                  digit_err <= 1'b1;
               end
            end
            ENTER_OP: begin
               op        <= sw[1:0];
               digit_err <= 1'b0;
               state     <= ENTER_B;
            end
            ENTER_B: begin
               // b = 0 with divide is passed through; the datapath owns that case.
               if (sw <= 4'd9) begin
                  b              <= sw;
                  digit_err      <= 1'b0;
                  state          <= DONE;
                  operands_valid <= 1'b1;
               end else begin
                  digit_err <= 1'b1;
               end
            end
            default: begin
               state          <= ENTER_A;
               operands_valid <= 1'b0;
            end
         endcase
      end
   end

   assign stage = state;

endmodule

// File: doc/calc_operand_entry.md
# calc_operand_entry

Operand-entry sequencer for the four-function calculator datapath. It turns slide-switch settings and two raw push-buttons into a validated operand pair and operator: `a`, `op`, then `b`. The outputs `a`, `b` and `op` drive the calculator arithmetic/display block directly. It debounces and edge-detects the buttons, steps a four-state entry FSM, rejects non-BCD digits, and flags when a complete operand set is held.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive clock edges a synchronized button level must differ from the debounced level before the debounced level toggles (5 ms at 50 MHz); must be ≥ 2.

Ports:
- clk  input  1  system clock; single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- sw  input  4  digit/operator switches; asynchronous to clk, sampled only on an accepted press.
- btn_enter  input  1  raw enter button, active high, asynchronous, bouncing.
- btn_clear  input  1  raw clear button, active high, asynchronous, bouncing.
- a  output  4  latched first operand, BCD 0–9.
- b  output  4  latched second operand, BCD 0–9.
- op  output  2  latched operator: 00 add, 01 subtract, 10 multiply, 11 divide.
- stage  output  2  current entry state: 00 ENTER_A, 01 ENTER_OP, 10 ENTER_B, 11 DONE.
- operands_valid  output  1  high while in DONE (a, b and op are complete and stable).
- digit_err  output  1  high after a rejected digit entry.

## Operation
- Button conditioning, per button:
  - A 2-flop synchronizer feeds a saturating counter.
  - The counter resets to 0 on any edge where the synchronized sample equals the debounced level.
  - The debounced level toggles on the DEBOUNCE_CYCLES-th consecutive differing edge.
  - press = debounced & ~debounced_d, a one-cycle pulse on the debounced rising edge only. Release produces no pulse.
- FSM acts only on edges where a press pulse is high. All outputs are registered.
- ENTER_A:
  - On enter_press with sw ≤ 9: a ← sw, digit_err ← 0, go to ENTER_OP.
  - On enter_press with sw > 9: a unchanged, digit_err ← 1, stay in ENTER_A.
- ENTER_OP: on enter_press: op ← sw[1:0], digit_err ← 0, go to ENTER_B. sw[3:2] is ignored; no rejection is possible in this state.
- ENTER_B:
  - On enter_press with sw ≤ 9: b ← sw, digit_err ← 0, go to DONE.
  - On enter_press with sw > 9: b unchanged, digit_err ← 1, stay in ENTER_B.
  - b = 0 with op = 11 is accepted; divide-by-zero handling belongs to the downstream block.
- DONE:
  - operands_valid = 1.
  - On enter_press: go to ENTER_A. a, b and op keep their values; operands_valid falls on that edge.
- clear_press, from any state: a, b, op ← 0; digit_err ← 0; go to ENTER_A.
- Simultaneous clear_press and enter_press: clear wins and enter is discarded.
- Held button: exactly one press pulse per debounced rising edge, no auto-repeat.

## Timing
- Reset (rst_n low, asynchronous):
  - Outputs: a=0, b=0, op=00, stage=00, operands_valid=0, digit_err=0.
  - Internal: synchronizers, debounced levels, debounced_d and counters all 0.
- Reset asserted mid-entry: the FSM abandons the partial entry. A button held through reset release is seen as a new press after the full debounce latency.
- Press latency, counting edge 1 as the first edge that samples the raw button high:
  - Synchronized sample is high after edge 2.
  - Debounced level is high after edge DEBOUNCE_CYCLES+2.
  - FSM outputs update at edge DEBOUNCE_CYCLES+3.
- Bounce: any raw glitch shorter than DEBOUNCE_CYCLES edges (after synchronization) produces no pulse and restarts the count.
- Release: the button must read low for DEBOUNCE_CYCLES consecutive edges before a new press can register.
- sw is sampled on the same edge the FSM transitions. sw must be stable during the press edge; it is not synchronized (quasi-static user input).
- operands_valid rises on the edge entering DONE and falls on the edge leaving DONE. a, b and op never change while operands_valid = 1.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4 and stimulus driven synchronously just after edges.
- Full entry: sw=7, enter; sw=01, enter; sw=3, enter → stage 00→01→10→11, a=7, op=01, b=3, operands_valid=1. Each step updates at edge 7 after its press starts.
- Bounce rejection: btn_enter pulsed high 3 edges, low 1, high 3 → no transition. A final high held 4+ edges → exactly one transition.
- Invalid digit: in ENTER_A, sw=12, enter → stage stays 00, digit_err=1, a unchanged. Then sw=5, enter → a=5, stage=01, digit_err=0.
- Clear priority: in ENTER_B with a=9, op=10, press clear and enter on the same cycle → stage=00, a=b=op=0, operands_valid=0.
- DONE re-entry: from DONE (a=4, op=11, b=0), enter → stage=00, operands_valid=0, a=4, b=0, op=11 retained.
- Reset mid-entry: in ENTER_OP, assert rst_n low between edges → all outputs go to reset values immediately, without waiting for a clock edge.
